regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 108 ++++++++++
 tb/tb_regfile_mp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with a post-reset
// clearing sweep, write-to-read bypass on the read ports, an unbypassed
// debug read port and a registered same-address write collision flag.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic              wea,
  input  logic [AW-1:0]     waa,
  input  logic [XLEN-1:0]   wda,
  input  logic              web,
  input  logic [AW-1:0]     wab,
  input  logic [XLEN-1:0]   wdb,
  input  logic [AW-1:0]     ra_dbg,
  output logic [XLEN-1:0]   rd_dbg,
  output logic              ready,
  output logic              wcoll
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic            wcoll_n;
  logic            run;
  logic            clr_en;
  logic            we_a, we_b;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] mem [NREG];

  // State, sweep index and collision flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
      wcoll <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      wcoll <= wcoll_n;
    end
  end

  // Next-state: sweep the array in CLEAR, then accept writes in RUN
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wcoll_n = 1'b0;
    clr_en  = 1'b0;
    run     = (state == RUN);
    ready   = run;
    case (state)
      CLEAR: begin
        clr_en = 1'b1;
        idx_n  = idx + 1'b1;
        if (idx == AW'(NREG - 1)) state_n = RUN;
      end
      RUN: begin
        wcoll_n = wea && web && (waa == wab) && (waa != '0);
      end
      default: state_n = CLEAR;
    endcase
    we_a = run && wea && (waa != '0);
    we_b = run && web && (wab != '0);
  end

  // Array update: B is applied after A so B wins a same-address collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_en) begin
        mem[idx] <= '0;
      end else begin
        if (we_a) mem[waa] <= wda;
        if (we_b) mem[wab] <= wdb;
      end
    end
  end

  // Bypassed read ports: B data, then A data, then the stored value
  always_comb begin
    rd      = '0;
    rd_addr = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_addr = ra[i*AW +: AW];
      if (run && rd_addr != '0) begin
        if (web && wab == rd_addr)
          rd[i*XLEN +: XLEN] = wdb;
        else if (wea && waa == rd_addr)
          rd[i*XLEN +: XLEN] = wda;
        else
          rd[i*XLEN +: XLEN] = mem[rd_addr];
      end
    end
  end

  // Debug read: stored value only, zero while clearing and for register 0
  always_comb begin
    rd_dbg = '0;
    if (run && ra_dbg != '0) rd_dbg = mem[ra_dbg];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a
// behavioural model (sweep counter, plain array, read-priority function).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;

  logic              clk;
  logic              reset;
  logic [NRD*AW-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic              wea, web;
  logic [AW-1:0]     waa, wab;
  logic [XLEN-1:0]   wda, wdb;
  logic [AW-1:0]     ra_dbg;
  logic [XLEN-1:0]   rd_dbg;
  logic              ready;
  logic              wcoll;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [XLEN-1:0] mem_m [NREG];
  bit              run_m = 1'b0;
  int              sweep_m = 0;
  bit              wcoll_m = 1'b0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd),
    .wea(wea), .waa(waa), .wda(wda),
    .web(web), .wab(wab), .wdb(wdb),
    .ra_dbg(ra_dbg), .rd_dbg(rd_dbg), .ready(ready), .wcoll(wcoll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (!run_m || a == 0) return '0;
    if (web && wab == a) return wdb;
    if (wea && waa == a) return wda;
    return mem_m[a];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [AW-1:0] a);
    if (!run_m || a == 0) return '0;
    return mem_m[a];
  endfunction

  // model of one rising edge, using the inputs currently applied
  task automatic model_edge();
    if (reset) begin
      run_m = 1'b0; sweep_m = 0; wcoll_m = 1'b0;
    end else if (!run_m) begin
      sweep_m++;
      wcoll_m = 1'b0;
      if (sweep_m == NREG) begin
        run_m = 1'b1;
        for (int k = 0; k < NREG; k++) mem_m[k] = '0;
      end
    end else begin
      wcoll_m = wea && web && (waa == wab) && (waa != 0);
      if (wea && waa != 0) mem_m[waa] = wda;
      if (web && wab != 0) mem_m[wab] = wdb;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    #1;
    for (int i = 0; i < NRD; i++)
      check_eq("rd_port", rd[i*XLEN +: XLEN], exp_rd(ra[i*AW +: AW]));
    check_eq("rd_dbg", rd_dbg, exp_dbg(ra_dbg));
    check_eq("ready", {31'b0, ready}, {31'b0, run_m});
    check_eq("wcoll", {31'b0, wcoll}, {31'b0, wcoll_m});
  endtask

  task automatic idle_inputs();
    wea = 1'b0; web = 1'b0; waa = '0; wab = '0; wda = '0; wdb = '0;
    ra = '0; ra_dbg = '0;
  endtask

  task automatic rand_inputs(input bit narrow);
    wea = 1'($urandom_range(0, 1));
    web = 1'($urandom_range(0, 1));
    waa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    wab = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    wda = $urandom;
    wdb = $urandom;
    for (int i = 0; i < NRD; i++)
      ra[i*AW +: AW] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    ra_dbg = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    tick();
    check_all();
    check_eq("reset_ready", {31'b0, ready}, 32'd0);
    check_eq("reset_rd", rd[31:0], 32'd0);

    // one-cycle reset then full sweep, with writes attempted throughout
    reset = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      rand_inputs(1'b0);
      check_all();
      tick();
    end
    idle_inputs();
    check_all();
    check_eq("ready_after_sweep", {31'b0, ready}, 32'd1);
    for (int a = 0; a < NREG; a++) begin
      ra_dbg = 5'(a);
      check_all();
      tick();
    end

    // single write with same-cycle bypass
    idle_inputs();
    wea = 1'b1; waa = 5'd5; wda = 32'hDEADBEEF; ra[0 +: AW] = 5'd5;
    check_all();
    check_eq("bypass_a", rd[31:0], 32'hDEADBEEF);
    tick();
    idle_inputs();
    ra_dbg = 5'd5;
    check_all();
    check_eq("dbg5", rd_dbg, 32'hDEADBEEF);

    // same-address collision: B wins, wcoll pulses once
    wea = 1'b1; web = 1'b1; waa = 5'd7; wab = 5'd7; wda = 32'h11; wdb = 32'h22;
    ra[0 +: AW] = 5'd7;
    check_all();
    check_eq("coll_bypass", rd[31:0], 32'h22);
    tick();
    idle_inputs();
    ra_dbg = 5'd7;
    check_all();
    check_eq("coll_reg7", rd_dbg, 32'h22);
    check_eq("wcoll_pulse", {31'b0, wcoll}, 32'd1);
    tick();
    check_all();
    check_eq("wcoll_drop", {31'b0, wcoll}, 32'd0);

    // writes to register 0 are discarded
    wea = 1'b1; waa = 5'd0; wda = 32'hFFFFFFFF;
    web = 1'b1; wab = 5'd0; wdb = 32'h12345678;
    check_all();
    check_eq("r0_bypass", rd[31:0], 32'd0);
    tick();
    idle_inputs();
    check_all();
    check_eq("r0_dbg", rd_dbg, 32'd0);
    check_eq("r0_wcoll", {31'b0, wcoll}, 32'd0);

    // different-address dual write, four read ports
    wea = 1'b1; waa = 5'd3; wda = 32'h33330003;
    web = 1'b1; wab = 5'd9; wdb = 32'h99990009;
    ra = {5'd3, 5'd0, 5'd9, 5'd3};
    check_all();
    check_eq("dual_p0", rd[0*XLEN +: XLEN], 32'h33330003);
    check_eq("dual_p1", rd[1*XLEN +: XLEN], 32'h99990009);
    check_eq("dual_p2", rd[2*XLEN +: XLEN], 32'd0);
    check_eq("dual_p3", rd[3*XLEN +: XLEN], 32'h33330003);
    tick();
    idle_inputs();
    ra_dbg = 5'd3;
    check_all();
    check_eq("dual_reg3", rd_dbg, 32'h33330003);
    tick();
    ra_dbg = 5'd9;
    check_all();
    check_eq("dual_reg9", rd_dbg, 32'h99990009);
    tick();

    // randomized run traffic, narrow addresses for collisions, then wide
    for (int k = 0; k < 400; k++) begin
      rand_inputs(k < 200);
      check_all();
      tick();
    end

    // reset restarted mid-sweep; previously written reg31 must be cleared
    idle_inputs();
    wea = 1'b1; waa = 5'd31; wda = 32'hA5;
    check_all();
    tick();
    idle_inputs();
    ra_dbg = 5'd31;
    check_all();
    check_eq("reg31_written", rd_dbg, 32'hA5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_all();
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      check_all();
      tick();
      n++;
    end
    check_eq("ready_latency", 32'(n), 32'd32);
    ra_dbg = 5'd31;
    check_all();
    check_eq("reg31_cleared", rd_dbg, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
